// File: rtl/ysyx_22041071_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, arbitrates redirects, one outstanding imem request.
// Define YSYX_22041071_TRAP_EN to add the trap/mret redirect port (top priority).
module ysyx_22041071_fetch_ctrl #(
    parameter int unsigned       ADDR_W     = 64,
    parameter int unsigned       INST_W     = 32,
    parameter logic [ADDR_W-1:0] START_ADDR = 64'h8000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jal_taken,
    input  logic [ADDR_W-1:0] jal_target,
    input  logic              jalr_taken,
    input  logic [ADDR_W-1:0] jalr_target,
`ifdef YSYX_22041071_TRAP_EN
    input  logic              trap_taken,
    input  logic [ADDR_W-1:0] trap_target,
`endif
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic [31:0]       redirect_cnt
);

`ifndef YSYX_22041071_TRAP_EN
    logic              trap_taken;
    logic [ADDR_W-1:0] trap_target;
    assign trap_taken  = 1'b0;
    assign trap_target = '0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              kill_q, kill_d;
    logic              buf_vld_q, buf_vld_d;
    logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;
    logic [INST_W-1:0] buf_inst_q, buf_inst_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic [INST_W-1:0] skid_inst_q, skid_inst_d;
    logic [31:0]       cnt_q, cnt_d;

    logic              redir;
    logic [ADDR_W-1:0] redir_raw;
    logic [ADDR_W-1:0] redir_tgt;
    logic              hs;
    logic              rsp;
    logic              consume;

    assign redir   = trap_taken | jalr_taken | jal_taken | br_taken;
    assign hs      = (state_q == S_REQ) && imem_req_ready;
    assign rsp     = (state_q == S_WAIT) && imem_rsp_valid;
    assign consume = buf_vld_q && id_ready;

    always_comb begin
        redir_raw = br_target;
        if (trap_taken) begin
            redir_raw = trap_target;
        end else if (jalr_taken) begin
            redir_raw = jalr_target;
        end else if (jal_taken) begin
            redir_raw = jal_target;
        end
    end

    assign redir_tgt = redir_raw & ALIGN_MASK;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= START_ADDR;
            req_pc_q    <= '0;
            kill_q      <= 1'b0;
            buf_vld_q   <= 1'b0;
            buf_pc_q    <= '0;
            buf_inst_q  <= '0;
            skid_pc_q   <= '0;
            skid_inst_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            kill_q      <= kill_d;
            buf_vld_q   <= buf_vld_d;
            buf_pc_q    <= buf_pc_d;
            buf_inst_q  <= buf_inst_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (hs) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (redir || kill_q) begin
                        state_d = S_REQ;
                    end else if (buf_vld_q && !id_ready) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (redir || id_ready) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        kill_d      = kill_q;
        buf_vld_d   = buf_vld_q;
        buf_pc_d    = buf_pc_q;
        buf_inst_d  = buf_inst_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        cnt_d       = cnt_q;
        if (hs) req_pc_d = pc_q;
        if (consume) buf_vld_d = 1'b0;
        if (rsp) begin
            if (kill_q) begin
                kill_d = 1'b0;
            end else begin
                pc_d = pc_q + ADDR_W'(4);
                if (buf_vld_q && !id_ready) begin
                    skid_pc_d   = req_pc_q;
                    skid_inst_d = imem_rsp_data;
                end else begin
                    buf_vld_d  = 1'b1;
                    buf_pc_d   = req_pc_q;
                    buf_inst_d = imem_rsp_data;
                end
            end
        end
        // HOLD always has a full buffer, so id_ready here frees it for the skid
        if ((state_q == S_HOLD) && id_ready) begin
            buf_vld_d  = 1'b1;
            buf_pc_d   = skid_pc_q;
            buf_inst_d = skid_inst_q;
        end
        if (redir) begin
            pc_d      = redir_tgt;
            buf_vld_d = 1'b0;
            cnt_d     = cnt_q + 32'd1;
            kill_d    = ((state_q == S_WAIT) && !imem_rsp_valid && kill_q)
                      || ((state_q == S_WAIT) && !imem_rsp_valid)
                      || hs;
        end
    end

    always_comb begin
        imem_req_valid = (state_q == S_REQ);
        imem_req_addr  = pc_q;
        id_valid       = buf_vld_q;
        id_pc          = buf_pc_q;
        id_inst        = buf_inst_q;
        redirect_cnt   = cnt_q;
    end

endmodule

// File: tb/tb_ysyx_22041071_fetch_ctrl.sv
// Bench for ysyx_22041071_fetch_ctrl: in-order fetch-stream model plus directed scenarios.
// Define YSYX_22041071_TRAP_EN to also exercise the trap redirect.
module tb_ysyx_22041071_fetch_ctrl;

    localparam logic [63:0] START = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        br_taken, jal_taken, jalr_taken, trap_taken;
    logic [63:0] br_target, jal_target, jalr_target, trap_target;
    logic        imem_req_valid, imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid, id_ready;
    logic [63:0] id_pc;
    logic [31:0] id_inst;
    logic [31:0] redirect_cnt;

    int          n_cmp = 0;
    int          n_bad = 0;

    int          mem_lat;
    int          mem_cnt;
    logic [63:0] mem_addr;
    logic        inject_rsp;

    logic [63:0] m_fetch, m_expect;
    logic [31:0] m_cnt;
    logic        exp_empty, hold_prev;
    logic [63:0] hp_pc;
    logic [31:0] hp_inst;
    int          cyc;
    logic [63:0] hs_addr[$];
    int          hs_cyc[$];
    logic [63:0] cons_pc[$];

    ysyx_22041071_fetch_ctrl #(
        .ADDR_W(64),
        .INST_W(32),
        .START_ADDR(START)
    ) dut (
        .clk(clk),
        .reset(reset),
        .br_taken(br_taken),
        .br_target(br_target),
        .jal_taken(jal_taken),
        .jal_target(jal_target),
        .jalr_taken(jalr_taken),
        .jalr_target(jalr_target),
`ifdef YSYX_22041071_TRAP_EN
        .trap_taken(trap_taken),
        .trap_target(trap_target),
`endif
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .id_valid(id_valid),
        .id_ready(id_ready),
        .id_pc(id_pc),
        .id_inst(id_inst),
        .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Memory responder plus reference model, sampled 1 time unit before each rising edge
    initial begin : monitor
        logic        redir;
        logic [63:0] tgt;
        forever begin
            @(negedge clk);
            #1;
            imem_rsp_valid = inject_rsp;
            imem_rsp_data  = inject_rsp ? 32'hDEAD_BEEF : 32'h0;
            if (reset) begin
                mem_cnt = 0;
            end else if (mem_cnt != 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(mem_addr);
                end
            end
            #3;
            cyc++;
            if (reset) begin
                chk("rst_req_valid", imem_req_valid, 0);
                chk("rst_req_addr", imem_req_addr, START);
                chk("rst_id_valid", id_valid, 0);
                chk("rst_id_pc", id_pc, 0);
                chk("rst_id_inst", id_inst, 0);
                chk("rst_cnt", redirect_cnt, 0);
                m_fetch   = START;
                m_expect  = START;
                m_cnt     = 0;
                exp_empty = 1'b0;
                hold_prev = 1'b0;
            end else begin
                chk("cnt", redirect_cnt, m_cnt);
                if (exp_empty) chk("flush_empty", id_valid, 0);
                if (hold_prev) begin
                    chk("hold_valid", id_valid, 1);
                    chk("hold_pc", id_pc, hp_pc);
                    chk("hold_inst", id_inst, hp_inst);
                end
                if (imem_req_valid) begin
                    chk("req_addr", imem_req_addr, m_fetch);
                    chk("one_outstanding", mem_cnt, 0);
                end
                redir = trap_taken | jalr_taken | jal_taken | br_taken;
                if (trap_taken)      tgt = trap_target;
                else if (jalr_taken) tgt = jalr_target;
                else if (jal_taken)  tgt = jal_target;
                else                 tgt = br_target;
                tgt = tgt & ~64'h3;
                if (imem_req_valid && imem_req_ready) begin
                    hs_addr.push_back(imem_req_addr);
                    hs_cyc.push_back(cyc);
                    mem_cnt  = mem_lat;
                    mem_addr = imem_req_addr;
                    m_fetch  = m_fetch + 64'd4;
                end
                if (id_valid && id_ready) begin
                    chk("deliver_pc", id_pc, m_expect);
                    chk("deliver_inst", id_inst, mem_word(id_pc));
                    cons_pc.push_back(id_pc);
                    m_expect = m_expect + 64'd4;
                end
                hold_prev = id_valid && !id_ready && !redir;
                hp_pc     = id_pc;
                hp_inst   = id_inst;
                exp_empty = redir;
                if (redir) begin
                    m_fetch  = tgt;
                    m_expect = tgt;
                    m_cnt    = m_cnt + 32'd1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        hs_addr.delete();
        hs_cyc.delete();
        cons_pc.delete();
    endtask

    task automatic wait_req(input logic [63:0] a, input int budget,
                            input string name);
        for (int i = 0; i < budget; i++) begin
            if (imem_req_valid && imem_req_addr == a) break;
            @(negedge clk);
        end
        chk(name, imem_req_valid && imem_req_addr == a, 1);
    endtask

    task automatic wait_idv(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (id_valid) break;
            @(negedge clk);
        end
        chk(name, id_valid, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [15:0] rdy_pat;
        logic [7:0]  mrdy_pat;
        logic [31:0] cnt_exp;
        reset = 1'b1;
        {br_taken, jal_taken, jalr_taken, trap_taken} = '0;
        br_target = '0; jal_target = '0;
        jalr_target = '0; trap_target = '0;
        imem_req_ready = 1'b1;
        id_ready = 1'b1;
        inject_rsp = 1'b0;
        mem_lat = 1;
        mem_cnt = 0;
        mem_addr = '0;
        cyc = 0;
        #2;
        chk("t0_req_valid", imem_req_valid, 0);
        chk("t0_req_addr", imem_req_addr, START);
        chk("t0_id_valid", id_valid, 0);
        chk("t0_cnt", redirect_cnt, 0);

        // Streaming with 1-cycle memory
        @(negedge clk);
        do_reset();
        chk("idle_no_req", imem_req_valid, 0);
        tick(1);
        chk("first_req_valid", imem_req_valid, 1);
        chk("first_req_addr", imem_req_addr, START);
        tick(12);
        chk("a_hs_count", hs_addr.size() >= 3, 1);
        chk("a_hs0", hs_addr[0], 64'h8000_0000);
        chk("a_hs1", hs_addr[1], 64'h8000_0004);
        chk("a_hs2", hs_addr[2], 64'h8000_0008);
        chk("a_rate", hs_cyc[1] - hs_cyc[0], 2);
        chk("a_cons0", cons_pc[0], 64'h8000_0000);
        chk("a_cons1", cons_pc[1], 64'h8000_0004);
        chk("a_cnt", redirect_cnt, 0);

        // Decode stall: buffer holds, skid fills, no third request
        id_ready = 1'b0;
        do_reset();
        wait_idv(20, "b_first_valid");
        repeat (6) begin
            tick(1);
            chk("b_hold_valid", id_valid, 1);
            chk("b_hold_pc", id_pc, 64'h8000_0000);
        end
        chk("b_no_third_req", hs_addr.size(), 2);
        chk("b_req_idle", imem_req_valid, 0);
        id_ready = 1'b1;
        tick(1);
        chk("b_rel_valid", id_valid, 1);
        chk("b_rel_pc", id_pc, 64'h8000_0004);
        chk("b_rel_inst", id_inst, mem_word(64'h8000_0004));
        tick(6);

        // JAL while waiting for 0x8000_0008
        mem_lat = 3;
        do_reset();
        wait_req(64'h8000_0008, 30, "c_req8");
        tick(1);
        jal_taken = 1'b1;
        jal_target = 64'h8000_0100;
        tick(1);
        jal_taken = 1'b0;
        chk("c_kill_v0", id_valid, 0);
        chk("c_cnt", redirect_cnt, 1);
        tick(1);
        chk("c_kill_v1", id_valid, 0);
        chk("c_kill_wait", imem_req_valid, 0);
        tick(1);
        chk("c_kill_v2", id_valid, 0);
        chk("c_redir_valid", imem_req_valid, 1);
        chk("c_redir_addr", imem_req_addr, 64'h8000_0100);
        wait_idv(20, "c_new_valid");
        chk("c_new_pc", id_pc, 64'h8000_0100);

        // Simultaneous branch/JAL/JALR: JALR wins, target aligned
        br_taken = 1'b1;  br_target = 64'h8000_0200;
        jal_taken = 1'b1; jal_target = 64'h8000_0300;
        jalr_taken = 1'b1; jalr_target = 64'h8000_0403;
        tick(1);
        {br_taken, jal_taken, jalr_taken} = '0;
        chk("d_addr", imem_req_addr, 64'h8000_0400);
        chk("d_cnt", redirect_cnt, 2);
        wait_req(64'h8000_0400, 20, "d_req");
        wait_idv(20, "d_valid");
        chk("d_pc", id_pc, 64'h8000_0400);
        cnt_exp = 2;

`ifdef YSYX_22041071_TRAP_EN
        trap_taken = 1'b1; trap_target = 64'h8000_0010;
        jalr_taken = 1'b1; jalr_target = 64'h8000_0020;
        tick(1);
        {trap_taken, jalr_taken} = '0;
        chk("e_addr", imem_req_addr, 64'h8000_0010);
        cnt_exp = cnt_exp + 1;
        chk("e_cnt", redirect_cnt, cnt_exp);
        wait_req(64'h8000_0010, 20, "e_req");
`endif

        // PC wraps from all-ones to zero
        jal_taken = 1'b1;
        jal_target = 64'hFFFF_FFFF_FFFF_FFFF;
        tick(1);
        jal_taken = 1'b0;
        cnt_exp = cnt_exp + 1;
        chk("f_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("f_cnt", redirect_cnt, cnt_exp);
        wait_req(64'h0, 30, "f_wrap_req");

        // Mixed backpressure with redirects in flight
        mem_lat = 2;
        rdy_pat = 16'b1011_0010_1110_0101;
        mrdy_pat = 8'b1101_0111;
        for (int i = 0; i < 48; i++) begin
            id_ready = rdy_pat[i % 16];
            imem_req_ready = mrdy_pat[i % 8];
            jalr_taken = (i == 20);
            jalr_target = 64'h8000_1002;
            br_taken = (i == 33);
            br_target = 64'h8000_2000;
            tick(1);
        end
        {jalr_taken, br_taken} = '0;
        id_ready = 1'b1;
        imem_req_ready = 1'b1;
        tick(10);
        cnt_exp = cnt_exp + 2;
        chk("g_cnt", redirect_cnt, cnt_exp);

        // Reset in WAIT with a full buffer
        mem_lat = 4;
        id_ready = 1'b0;
        do_reset();
        wait_idv(30, "h_valid");
        tick(2);
        chk("h_pre_valid", id_valid, 1);
        chk("h_pre_wait", imem_req_valid, 0);
        reset = 1'b1;
        #2;
        chk("h_req_valid", imem_req_valid, 0);
        chk("h_req_addr", imem_req_addr, START);
        chk("h_id_valid", id_valid, 0);
        chk("h_id_pc", id_pc, 0);
        chk("h_id_inst", id_inst, 0);
        chk("h_cnt", redirect_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        inject_rsp = 1'b1;
        tick(1);
        inject_rsp = 1'b0;
        chk("h_late_v0", id_valid, 0);
        repeat (3) begin
            tick(1);
            chk("h_late_v", id_valid, 0);
        end
        id_ready = 1'b1;
        wait_idv(30, "h_restart_valid");
        chk("h_restart_pc", id_pc, START);
        tick(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
